pe: RTL and testbench
=====================

PE -- requirements
Module: pe

Interface
REQ-001 The block SHALL have parameter XLEN, default 16, giving the operand and result width in bits (two's complement).
REQ-002 The block SHALL have parameter ACC_W, default 2*XLEN+8, giving the internal accumulator width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; synchronous and active-high (asserted when 1), despite the legacy name.
REQ-005 in_valid  input  1  operand pair valid this cycle.
REQ-006 flush  input  1  clear accumulator.
REQ-007 out_en  input  1  emit result this cycle.
REQ-008 calc_bias  input  1  this cycle adds a bias instead of a product.
REQ-009 calc_relu  input  1  apply ReLU to the emitted result.
REQ-010 x  input  XLEN signed  activation operand.
REQ-011 weight  input  XLEN signed  weight operand, or bias value when calc_bias=1.
REQ-012 result_r  output  XLEN signed  registered result.
REQ-013 out_valid_r  output  1  registered one-cycle pulse qualifying result_r.
REQ-014 illegal_uop  output  1  registered flag for an illegal control combination.

Function
REQ-015 Priority per cycle SHALL be: flush, then illegal check, then normal operation.
REQ-016 flush=1 SHALL clear acc to 0 at the next edge, ignore all other inputs that cycle, and force out_valid_r=0 and illegal_uop=0; it is never illegal.
REQ-017 A cycle with flush=0 SHALL be illegal when (calc_bias|calc_relu|out_en)&~in_valid, or when calc_relu&~out_en.
REQ-018 An illegal cycle SHALL leave acc and result_r unchanged, drive out_valid_r=0 and illegal_uop=1 at the next edge; illegal_uop SHALL be 0 after every legal cycle.
REQ-019 Legal cycle, in_valid=1, calc_bias=0: acc_next = acc + sign-extended x*weight (full 2*XLEN product).
REQ-020 Legal cycle, in_valid=1, calc_bias=1: acc_next = acc + sign-extended weight; x is ignored.
REQ-021 Legal cycle with in_valid=0 and no other control SHALL hold acc; idle cycles are legal.
REQ-022 Accumulator arithmetic SHALL wrap modulo 2^ACC_W.
REQ-023 out_en=1 on a legal cycle SHALL load result_r from acc_next (including this cycle's term) at the same edge, set out_valid_r=1 for exactly that cycle, and clear acc to 0.
REQ-024 The emitted value SHALL be acc_next saturated to the signed XLEN range [-2^(XLEN-1), 2^(XLEN-1)-1]; if calc_relu=1, negative values SHALL become 0 before output.
REQ-025 Latency from the out_en input cycle to result_r/out_valid_r SHALL be one clock.
REQ-026 result_r SHALL hold its last value until the next legal out_en cycle.
REQ-027 out_valid_r SHALL be 0 on every cycle without a legal out_en.
REQ-028 Back-to-back out_en cycles SHALL each emit, each starting from a cleared acc.

Reset
REQ-029 rst_n=1 at a rising edge SHALL set acc=0, result_r=0, out_valid_r=0, and illegal_uop=0, overriding all other inputs including an operation in progress.
REQ-030 After reset deassertion the block SHALL accept operations on the first following edge.

Verification
REQ-031 x=1, weight=1: 32 cycles in_valid=1, then in_valid+calc_bias+out_en -> next cycle result_r=33, out_valid_r=1 for one cycle, illegal_uop=0.
REQ-032 32 MAC cycles of 1*1, then in_valid=0 with calc_bias=1 and out_en=1 -> illegal_uop=1, out_valid_r=0, result_r unchanged; the next flush clears acc and illegal_uop=0.
REQ-033 Accumulate x=-3, weight=5 four times, then out_en with calc_relu=1 -> result_r=0; the same sequence without calc_relu -> result_r=-60.
REQ-034 XLEN=16: accumulate 127*127 ten times, then out_en -> result_r=32767 (saturated); the following out_en-only MAC of 1*1 -> result_r=1.
REQ-035 Assert rst_n mid-accumulation for one cycle -> all outputs 0; a following single MAC 2*3 with out_en -> result_r=6.
REQ-036 flush held together with in_valid, out_en, and calc_bias -> acc=0, out_valid_r=0, illegal_uop=0 for every cycle it is held.

Source files
------------

// File: rtl/pe.sv
// Multiply-accumulate processing element: accumulates x*weight (or a bias) and
// emits a saturated, optionally ReLU-clipped result with a one-cycle valid pulse.
module pe #(
  parameter int XLEN  = 16,
  parameter int ACC_W = 2*XLEN+8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   flush,
  input  logic                   out_en,
  input  logic                   calc_bias,
  input  logic                   calc_relu,
  input  logic signed [XLEN-1:0] x,
  input  logic signed [XLEN-1:0] weight,
  output logic signed [XLEN-1:0] result_r,
  output logic                   out_valid_r,
  output logic                   illegal_uop
);

  // Handshake: out_valid_r is a single-cycle pulse, high exactly one clock after
  // a legal out_en cycle; result_r is only meaningful (and only changes) then.

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-XLEN+1){1'b0}}, {(XLEN-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [XLEN-1:0]  result_q, result_d;
  logic                    out_valid_q, out_valid_d;
  logic                    illegal_q, illegal_d;

  logic [2*XLEN-1:0]       x_ext, w_ext, prod;
  logic signed [ACC_W-1:0] term, acc_sum;
  logic signed [XLEN-1:0]  sat_val;
  logic                    illegal;

  always_comb begin
    x_ext   = {{XLEN{x[XLEN-1]}}, x};
    w_ext   = {{XLEN{weight[XLEN-1]}}, weight};
    // Low 2*XLEN bits of the product are the same for signed and unsigned operands.
    prod    = x_ext * w_ext;
    term    = calc_bias ? {{(ACC_W-XLEN){weight[XLEN-1]}}, weight}
                        : {{(ACC_W-2*XLEN){prod[2*XLEN-1]}}, prod};
    acc_sum = acc_q + (in_valid ? term : '0);

    if (acc_sum > SAT_MAX)      sat_val = {1'b0, {(XLEN-1){1'b1}}};
    else if (acc_sum < SAT_MIN) sat_val = {1'b1, {(XLEN-1){1'b0}}};
    else                        sat_val = acc_sum[XLEN-1:0];
    if (calc_relu && sat_val[XLEN-1]) sat_val = '0;

    illegal = ~flush & ((((calc_bias | calc_relu | out_en) & ~in_valid)) | (calc_relu & ~out_en));

    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal;

    if (flush) begin
      acc_d = '0;
    end else if (!illegal) begin
      if (out_en) begin
        acc_d       = '0;
        result_d    = sat_val;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign result_r    = result_q;
  assign out_valid_r = out_valid_q;
  assign illegal_uop = illegal_q;

endmodule

// File: tb/tb_pe.sv
// Randomised and directed bench for pe: a driver feeds a high-level model that
// queues expected results; a monitor pops and compares after every clock edge.
module tb_pe;

  localparam int XLEN  = 16;
  localparam int ACC_W = 2*XLEN+8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   flush = 1'b0;
  logic                   out_en = 1'b0;
  logic                   calc_bias = 1'b0;
  logic                   calc_relu = 1'b0;
  logic signed [XLEN-1:0] x = '0;
  logic signed [XLEN-1:0] weight = '0;
  logic signed [XLEN-1:0] result_r;
  logic                   out_valid_r;
  logic                   illegal_uop;

  pe #(.XLEN(XLEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .out_en(out_en),
    .calc_bias(calc_bias), .calc_relu(calc_relu), .x(x), .weight(weight),
    .result_r(result_r), .out_valid_r(out_valid_r), .illegal_uop(illegal_uop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            ill;
    logic            vld;
    logic [XLEN-1:0] res;
  } cyc_t;

  logic [XLEN-1:0] exp_q[$];
  cyc_t            chk_q[$];

  int     n_checks = 0;
  int     n_errors = 0;
  longint m_acc = 0;
  longint m_res = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic over the documented rules.
  task automatic drive(input bit rst, input bit iv, input bit fl, input bit oe,
                       input bit cb, input bit cr,
                       input logic signed [XLEN-1:0] xv, input logic signed [XLEN-1:0] wv);
    longint v;
    bit     ill;
    cyc_t   c;
    @(negedge clk);
    rst_n = rst; in_valid = iv; flush = fl; out_en = oe;
    calc_bias = cb; calc_relu = cr; x = xv; weight = wv;
    ill = !fl && (((cb || cr || oe) && !iv) || (cr && !oe));
    c.ill = 1'b0; c.vld = 1'b0;
    if (rst) begin
      m_acc = 0; m_res = 0;
    end else if (fl) begin
      m_acc = 0;
    end else if (ill) begin
      c.ill = 1'b1;
    end else begin
      if (iv) begin
        m_acc = m_acc + (cb ? longint'(wv) : longint'(xv) * longint'(wv));
        m_acc = (m_acc <<< (64-ACC_W)) >>> (64-ACC_W);
      end
      if (oe) begin
        v = m_acc;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (cr && v < 0) v = 0;
        m_res = v;
        m_acc = 0;
        c.vld = 1'b1;
        exp_q.push_back(XLEN'(v));
      end
    end
    c.res = XLEN'(m_res);
    chk_q.push_back(c);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic mac(input int n, input logic signed [XLEN-1:0] xv, input logic signed [XLEN-1:0] wv);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, xv, wv);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc_t c;
    logic [XLEN-1:0] e;
    #1;
    if (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check("illegal_uop", longint'(illegal_uop), longint'(c.ill));
      check("out_valid_r", longint'(out_valid_r), longint'(c.vld));
      check("result_hold", longint'(result_r), longint'($signed(c.res)));
    end
    if (out_valid_r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result_r", longint'(result_r), longint'($signed(e)));
      end
    end
  end

  initial begin
    bit iv, fl, oe, cb, cr, rs;
    logic signed [XLEN-1:0] xv, wv;

    drive(1, 0, 0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 1, 0, 0, 16'sd4, 16'sd4);
    idle();

    mac(32, 16'sd1, 16'sd1);
    drive(0, 1, 0, 1, 1, 0, 16'sd0, 16'sd1);
    idle();

    mac(32, 16'sd1, 16'sd1);
    drive(0, 0, 0, 1, 1, 0, 16'sd0, 16'sd1);
    drive(0, 0, 1, 0, 0, 0, '0, '0);
    drive(0, 1, 0, 1, 0, 0, 16'sd0, 16'sd0);

    mac(4, -16'sd3, 16'sd5);
    drive(0, 1, 0, 1, 0, 1, -16'sd3, 16'sd5);
    mac(3, -16'sd3, 16'sd5);
    drive(0, 1, 0, 1, 0, 0, -16'sd3, 16'sd5);
    drive(0, 1, 0, 0, 0, 1, 16'sd1, 16'sd1);
    drive(0, 1, 1, 0, 0, 0, '0, '0);

    mac(10, 16'sd127, 16'sd127);
    drive(0, 1, 0, 1, 0, 0, 16'sd0, 16'sd0);
    drive(0, 1, 0, 1, 0, 0, 16'sd1, 16'sd1);
    mac(10, -16'sd32768, 16'sd32767);
    drive(0, 1, 0, 1, 0, 0, 16'sd0, 16'sd0);

    mac(5, 16'sd9, 16'sd9);
    drive(1, 1, 0, 1, 0, 0, 16'sd9, 16'sd9);
    drive(0, 1, 0, 1, 0, 0, 16'sd2, 16'sd3);

    mac(3, 16'sd7, 16'sd7);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1, 1, 0, 16'sd100, 16'sd100);
    drive(0, 1, 0, 1, 0, 0, 16'sd1, 16'sd2);
    drive(0, 1, 0, 1, 0, 0, 16'sd3, 16'sd2);

    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 60) == 0);
      fl = ($urandom_range(0, 15) == 0);
      iv = ($urandom_range(0, 4) != 0);
      oe = ($urandom_range(0, 5) == 0);
      cb = ($urandom_range(0, 7) == 0);
      cr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        xv = XLEN'($urandom);
        wv = XLEN'($urandom);
      end else begin
        xv = XLEN'($signed($urandom_range(0, 400)) - 200);
        wv = XLEN'($signed($urandom_range(0, 400)) - 200);
      end
      drive(rs, iv, fl, oe, cb, cr, xv, wv);
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    check("exp_q_drained", longint'(exp_q.size()), 0);
    check("chk_q_drained", longint'(chk_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
